// File: rtl/stream_serializer_pkg.sv
// Shared state encoding for the stream serializer slice.
package stream_serializer_pkg;
  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_SEND = 1'b1;
endpackage

// File: rtl/stream_serializer_beat_counter.sv
// Beat position within the held word: load on accept, step on retire, flag last beat.
module stream_serializer_beat_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] lim_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
      lim_q <= limit_i;
    end else if (inc && (cnt_q != lim_q)) begin
      // saturate at the word's beat count; no wrap inside a word
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == lim_q);
endmodule

// File: rtl/stream_serializer.sv
// Wide-to-narrow serializer: one word per handshake, emitted LSB slice first,
// with a per-word beat count and zero-bubble back-to-back words.
module stream_serializer
  import stream_serializer_pkg::*;
#(
  parameter  int IN_WIDTH  = 128,
  parameter  int OUT_WIDTH = 32,
  localparam int RATIO     = IN_WIDTH / OUT_WIDTH,
  localparam int CNT_W     = $clog2(RATIO)
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 w_ready_o,
  input  logic                 w_valid_i,
  input  logic [IN_WIDTH-1:0]  w_data_i,
  input  logic [CNT_W-1:0]     w_beats_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [OUT_WIDTH-1:0] r_data_o,
  output logic                 r_last_o,
  output logic [CNT_W-1:0]     r_idx_o
);
  state_t                          state_q;
  logic [RATIO-1:0][OUT_WIDTH-1:0] held_q;
  logic [CNT_W-1:0]                beats_in;
  logic [CNT_W-1:0]                cnt;
  logic                            last;
  logic                            send;
  logic                            accept;
  logic                            retire;

  // Counts above RATIO-1 only exist when RATIO is not a power of two.
  if (RATIO == (1 << CNT_W)) begin : g_noclamp
    assign beats_in = w_beats_i;
  end else begin : g_clamp
    assign beats_in = (w_beats_i > CNT_W'(RATIO - 1)) ? CNT_W'(RATIO - 1) : w_beats_i;
  end

  assign send      = (state_q == ST_SEND);
  assign r_valid_o = send;
  assign r_last_o  = send & last;
  assign r_idx_o   = cnt;
  assign r_data_o  = held_q[cnt];
  // r_ready_i -> w_ready_o is the only combinational path through the block
  assign w_ready_o = !send || (r_last_o && r_ready_i);
  assign accept    = w_valid_i && w_ready_o;
  assign retire    = r_valid_o && r_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      held_q  <= '0;
    end else if (accept) begin
      state_q <= ST_SEND;
      held_q  <= w_data_i;
    end else if (retire && last) begin
      state_q <= ST_IDLE;
    end
  end

  stream_serializer_beat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .inc     (retire && !last),
    .limit_i (beats_in),
    .cnt_o   (cnt),
    .last_o  (last)
  );
endmodule

// File: tb/tb_stream_serializer.sv
// Self-checking bench for stream_serializer (128 -> 32, four beats max).
module tb_stream_serializer;
  localparam int IW = 128;
  localparam int OW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          w_ready_o;
  logic          w_valid_i = 1'b0;
  logic [IW-1:0] w_data_i  = '0;
  logic [1:0]    w_beats_i = '0;
  logic          r_valid_o;
  logic          r_ready_i = 1'b0;
  logic [OW-1:0] r_data_o;
  logic          r_last_o;
  logic [1:0]    r_idx_o;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [31:0] data; logic [1:0] idx; logic last; } beat_t;
  typedef struct { logic [127:0] d; logic [1:0] b; } word_t;
  typedef struct { logic [127:0] data; logic [1:0] beats; int exp_n; } vec_t;

  beat_t sb[$];
  word_t src[$];
  vec_t  tbl[8];

  stream_serializer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .w_ready_o (w_ready_o),
    .w_valid_i (w_valid_i),
    .w_data_i  (w_data_i),
    .w_beats_i (w_beats_i),
    .r_valid_o (r_valid_o),
    .r_ready_i (r_ready_i),
    .r_data_o  (r_data_o),
    .r_last_o  (r_last_o),
    .r_idx_o   (r_idx_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: inputs are stable from posedge+1 to the next posedge, so the
  // handshakes seen at negedge are exactly those that complete at the next edge.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (r_valid_o && r_ready_i) begin
        if (sb.size() == 0) begin
          chk("beat_unexpected", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("sb_data", r_data_o, e.data);
          chk("sb_idx", r_idx_o, e.idx);
          chk("sb_last", r_last_o, e.last);
        end
      end
      if (w_valid_i && w_ready_o)
        for (int b = 0; b <= int'(w_beats_i); b++)
          sb.push_back('{w_data_i[b*32 +: 32], b[1:0], (b == int'(w_beats_i))});
    end
  end

  initial begin
    int n;
    int vcnt;
    int acc;
    logic [127:0] w;

    tbl[0] = '{128'h44444444_33333333_22222222_11111111, 2'd3, 4};
    tbl[1] = '{128'h0, 2'd0, 1};
    tbl[2] = '{128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 2'd1, 2};
    tbl[3] = '{128'h01234567_89ABCDEF_FEDCBA98_76543210, 2'd2, 3};
    tbl[4] = '{128'hDEADBEEF_00000000_CAFEF00D_A5A5A5A5, 2'd3, 4};
    tbl[5] = '{128'h80000000_00000001_80000000_00000001, 2'd0, 1};
    tbl[6] = '{128'h5A5A5A5A_C3C3C3C3_0F0F0F0F_F0F0F0F0, 2'd2, 3};
    tbl[7] = '{128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 2'd1, 2};

    // reset and idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_r_valid", r_valid_o, 1'b0);
    chk("rst_w_ready", w_ready_o, 1'b1);
    chk("rst_r_last", r_last_o, 1'b0);
    chk("rst_r_idx", r_idx_o, 2'd0);
    chk("rst_r_data", r_data_o, 32'h0);
    vcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (r_valid_o) vcnt++;
    end
    chk("idle_no_beats", vcnt, 0);

    // full word, beats visible the cycle after accept
    r_ready_i = 1'b1;
    @(posedge clk); #1;
    w_valid_i = 1'b1; w_data_i = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA; w_beats_i = 2'd3;
    @(negedge clk);
    chk("full_w_ready", w_ready_o, 1'b1);
    @(posedge clk); #1;
    w_valid_i = 1'b0;
    w = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("full_valid", r_valid_o, 1'b1);
      chk("full_data", r_data_o, w[k*32 +: 32]);
      chk("full_idx", r_idx_o, k);
      chk("full_last", r_last_o, (k == 3));
    end
    @(negedge clk);
    chk("full_done_idle", r_valid_o, 1'b0);

    // short word then back-to-back word
    @(posedge clk); #1;
    w_valid_i = 1'b1; w_data_i = 128'h11; w_beats_i = 2'd0;
    @(posedge clk); #1;
    w_data_i = {64'h0, 32'h33, 32'h22}; w_beats_i = 2'd1;
    @(negedge clk);
    chk("b2b_data0", r_data_o, 32'h11);
    chk("b2b_last0", r_last_o, 1'b1);
    chk("b2b_w_ready", w_ready_o, 1'b1);
    @(posedge clk); #1;
    w_valid_i = 1'b0;
    @(negedge clk);
    chk("b2b_data1", r_data_o, 32'h22);
    chk("b2b_valid1", r_valid_o, 1'b1);
    chk("b2b_last1", r_last_o, 1'b0);
    @(negedge clk);
    chk("b2b_data2", r_data_o, 32'h33);
    chk("b2b_idx2", r_idx_o, 2'd1);
    chk("b2b_last2", r_last_o, 1'b1);
    @(negedge clk);
    chk("b2b_idle", r_valid_o, 1'b0);

    // backpressure on beat 2
    w = 128'h44440000_33330000_22220000_11110000;
    @(posedge clk); #1;
    w_valid_i = 1'b1; w_data_i = w; w_beats_i = 2'd3;
    @(posedge clk); #1;
    w_valid_i = 1'b0; w_data_i = '1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    r_ready_i = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", r_valid_o, 1'b1);
      chk("bp_data", r_data_o, w[64 +: 32]);
      chk("bp_idx", r_idx_o, 2'd2);
      chk("bp_w_ready", w_ready_o, 1'b0);
    end
    @(posedge clk); #1;
    r_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_resume2", r_data_o, w[64 +: 32]);
    @(negedge clk);
    chk("bp_resume3", r_data_o, w[96 +: 32]);
    chk("bp_last3", r_last_o, 1'b1);
    @(negedge clk);
    chk("bp_idle", r_valid_o, 1'b0);

    // reset after beat 1 retires
    @(posedge clk); #1;
    w_valid_i = 1'b1; w_data_i = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0; w_beats_i = 2'd3;
    @(posedge clk); #1;
    w_valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", r_valid_o, 1'b0);
    chk("mid_rst_idx", r_idx_o, 2'd0);
    chk("mid_rst_data", r_data_o, 32'h0);
    @(posedge clk); #1;
    w_valid_i = 1'b1; w_data_i = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0; w_beats_i = 2'd1;
    @(posedge clk); #1;
    w_valid_i = 1'b0;
    @(negedge clk);
    chk("post_rst_idx", r_idx_o, 2'd0);
    chk("post_rst_data", r_data_o, 32'hB0B0B0B0);
    @(negedge clk);
    chk("post_rst_last", r_last_o, 1'b1);
    @(negedge clk);

    // table-driven words; content checked by the scoreboard, length here
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      w_valid_i = 1'b1; w_data_i = tbl[i].data; w_beats_i = tbl[i].beats;
      @(posedge clk); #1;
      w_valid_i = 1'b0;
      n = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (r_valid_o && r_ready_i) n++;
        if (r_valid_o && r_last_o) break;
      end
      chk("tbl_nbeats", n, tbl[i].exp_n);
      @(negedge clk);
    end

    // random valid/ready behind a depth-4 flow-through FIFO model
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      acc = (w_valid_i && w_ready_o) ? 1 : 0;
      @(posedge clk); #1;
      if (acc != 0) void'(src.pop_front());
      if (cyc < 500 && src.size() < 4 && $urandom_range(0, 2) != 0)
        src.push_back('{{$urandom, $urandom, $urandom, $urandom}, 2'($urandom_range(0, 3))});
      w_valid_i = (src.size() > 0);
      if (src.size() > 0) begin
        w_data_i  = src[0].d;
        w_beats_i = src[0].b;
      end
      r_ready_i = (cyc >= 500) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    chk("rand_src_drained", src.size(), 0);
    chk("rand_sb_empty", sb.size(), 0);
    chk("rand_idle", r_valid_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stream_serializer.md
Name: stream_serializer

Overview:
- Downstream consumer of the flow-through stream FIFO.
- Accepts one wide word per handshake on its write side (the FIFO's read side) and emits it as a sequence of narrow beats, LSB slice first.
- Each word carries a beat count, so short words terminate early.
- Feeds narrow-datapath consumers, e.g. a 32-bit memory request port behind a 128-bit queue.

Parameters:
IN_WIDTH, 128, width of the input word; must be an integer multiple of OUT_WIDTH.
OUT_WIDTH, 32, width of one output beat.
RATIO (localparam), IN_WIDTH/OUT_WIDTH, maximum beats per word; must be >= 2.
CNT_W (localparam), $clog2(RATIO), beat counter / beat-count field width.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
w_ready_o  output  1  serializer can accept a word this cycle.
w_valid_i  input  1  input word valid.
w_data_i  input  IN_WIDTH  input word.
w_beats_i  input  CNT_W  beats to send minus one (0 -> 1 beat).
r_valid_o  output  1  output beat valid.
r_ready_i  input  1  downstream accepts beat.
r_data_o  output  OUT_WIDTH  current beat.
r_last_o  output  1  current beat is last of its word.
r_idx_o  output  CNT_W  index of current beat within word.

Behaviour:
- Single clock (clk); reset (rst) is synchronous and active-high. On rst=1 at a rising edge the following clear, regardless of any in-flight word:
  - state -> IDLE, beat counter -> 0, held word -> 0, held beat count -> 0;
  - r_valid_o -> 0, r_last_o -> 0, r_idx_o -> 0, r_data_o -> 0.
  - A partially sent word is discarded, with no further beats.
- Input handshake: word accepted when w_valid_i && w_ready_o at a rising edge.
- Output handshake: beat retired when r_valid_o && r_ready_i at a rising edge.
- States:
  - IDLE: r_valid_o=0, w_ready_o=1. On input accept -> SEND; latch w_data_i and w_beats_i, counter := 0.
  - SEND: r_valid_o=1.
    - Non-last beat retired: counter += 1, stay in SEND.
    - Last beat retired with no new input: -> IDLE.
- Outputs in SEND:
  - r_data_o = held[counter*OUT_WIDTH +: OUT_WIDTH].
  - r_idx_o = counter.
  - r_last_o = (counter == held beat count).
  - All three are driven from registers or from a mux of registered state only; no input-to-output combinational path on the data side.
- w_ready_o = (state==IDLE) || (r_last_o && r_ready_i). This is the only combinational input-to-output path (r_ready_i -> w_ready_o).
- Back-to-back words: if the last beat retires and a new word is accepted in the same cycle, stay in SEND, load the new word, counter := 0. There is no bubble: steady-state throughput is 1 beat/cycle.
- Latency: word accepted at edge t -> its beat 0 is visible on r_data_o after edge t (cycle t+1).
- Stall: while r_valid_o=1 and r_ready_i=0, r_data_o, r_idx_o and r_last_o are held stable. r_valid_o never drops without a handshake or reset.
- w_beats_i > RATIO-1 (only possible when RATIO is not a power of two) is clamped to RATIO-1 at latch time.
- The input word is latched only on accept. w_data_i changing while w_ready_o=0 has no effect.
- Counter never exceeds the held beat count; no wrap-around within a word.

Decomposition:
- No shared package needed; RATIO and CNT_W are local derived parameters.
- Optional sub-module: stream_beat_counter (load/increment/last-compare counter, CNT_W wide).
- Otherwise a single flat module, est. 150-200 lines.

Test Plan:
- Reset then idle: after rst, r_valid_o=0, w_ready_o=1; no beats emitted for 10 idle cycles.
- Full word, r_ready_i=1: word 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, w_beats_i=3 -> beats AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD on cycles t+1..t+4; r_idx_o 0..3; r_last_o only on DDDDDDDD.
- Short word and back-to-back: word1 w_beats_i=0 (low slice 0x11), word2 w_beats_i=1 (0x22, 0x33) presented continuously -> output 0x11(last), 0x22, 0x33(last) on consecutive cycles; w_ready_o=1 in the last-beat cycle.
- Backpressure: hold r_ready_i=0 for 5 cycles in the middle of beat 2 -> r_data_o and r_idx_o=2 stable, w_ready_o=0 throughout; resume -> beats 2,3 follow with no loss or duplication.
- Reset mid-word: assert rst after beat 1 retires -> next cycle r_valid_o=0; new word after reset starts at r_idx_o=0 with its own data.
- Chained with stream_fifo_flow_true (depth 4) under random valid/ready: scoreboard confirms every input word's beats appear in order, exactly once, with correct r_last_o.
